// File: rtl/boreal_cursor_reporter.sv
// boreal_cursor_reporter
//   Integrates per-sample predicted cursor velocities (signed fixed point,
//   pixels/sample) into pending integer deltas. The sub-pixel remainder is
//   carried from sample to sample. The block tracks a clamped absolute screen
//   position and emits 3-byte relative HID mouse reports {buttons, dx, dy} on
//   a byte-wide valid/ready stream.
//
// Ports
//   clk, rst        single clock, synchronous active-high reset
//   valid           vx_in/vy_in sample strobe (always accepted)
//   vx_in, vy_in    signed velocity, FRAC_BITS fractional bits
//   enable          permits starting new reports; integration always runs
//   buttons         live button state {mid, right, left}
//   out_tdata       report byte
//   out_tvalid      byte valid
//   out_tready      sink ready
//   out_tlast       marks the dy byte
//   pos_x, pos_y    tracked absolute position
//   sat_flag        sticky pending-accumulator saturation indicator
module boreal_cursor_reporter #(
  parameter int unsigned SCREEN_W  = 1920,
  parameter int unsigned SCREEN_H  = 1080,
  parameter int unsigned FRAC_BITS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid,
  input  logic [23:0] vx_in,
  input  logic [23:0] vy_in,
  input  logic        enable,
  input  logic [2:0]  buttons,
  output logic [7:0]  out_tdata,
  output logic        out_tvalid,
  input  logic        out_tready,
  output logic        out_tlast,
  output logic [11:0] pos_x,
  output logic [11:0] pos_y,
  output logic        sat_flag
);

  localparam int unsigned AW    = 32;  // working width for signed arithmetic
  localparam int unsigned PW    = 16;  // pending delta width
  localparam int unsigned POS_W = 12;
  localparam int unsigned BTN_W = 3;
  localparam int unsigned BYTE_W = 8;

  localparam logic signed [AW-1:0] ZERO     = '0;
  localparam logic signed [AW-1:0] PEND_HI  = AW'(32767);
  localparam logic signed [AW-1:0] PEND_LO  = -PEND_HI;
  localparam logic signed [AW-1:0] STEP_HI  = AW'(127);
  localparam logic signed [AW-1:0] STEP_LO  = -STEP_HI;
  localparam logic signed [AW-1:0] X_MAX    = $signed(AW'(SCREEN_W - 1));
  localparam logic signed [AW-1:0] Y_MAX    = $signed(AW'(SCREEN_H - 1));

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BTN,
    ST_DX,
    ST_DY
  } state_e;

  // Signed clamp to [lo, hi].
  function automatic logic signed [AW-1:0] clamp_s(
    input logic signed [AW-1:0] v,
    input logic signed [AW-1:0] lo,
    input logic signed [AW-1:0] hi
  );
    logic signed [AW-1:0] r;
    r = v;
    if (v < lo) begin
      r = lo;
    end else if (v > hi) begin
      r = hi;
    end
    return r;
  endfunction

  state_e                   state_q,    state_d;
  logic [FRAC_BITS-1:0]     frac_x_q,   frac_x_d;
  logic [FRAC_BITS-1:0]     frac_y_q,   frac_y_d;
  logic signed [PW-1:0]     pend_x_q,   pend_x_d;
  logic signed [PW-1:0]     pend_y_q,   pend_y_d;
  logic [POS_W-1:0]         pos_x_q,    pos_x_d;
  logic [POS_W-1:0]         pos_y_q,    pos_y_d;
  logic [BTN_W-1:0]         btn_last_q, btn_last_d;
  logic [BYTE_W-1:0]        ex_q,       ex_d;
  logic [BYTE_W-1:0]        ey_q,       ey_d;
  logic [BYTE_W-1:0]        tdata_q,    tdata_d;
  logic                     tvalid_q,   tvalid_d;
  logic                     tlast_q,    tlast_d;
  logic                     sat_q,      sat_d;

  logic signed [AW-1:0]     sum_x, sum_y;
  logic signed [AW-1:0]     int_x, int_y;
  logic signed [AW-1:0]     step_x, step_y;
  logic signed [AW-1:0]     tgt_x, tgt_y;
  logic signed [BYTE_W-1:0] eff_x, eff_y;
  logic signed [AW-1:0]     raw_x, raw_y;
  logic                     latch;
  logic                     hs;

  // A report is latched from IDLE when something is worth reporting.
  assign latch = (state_q == ST_IDLE) && enable &&
                 ((pend_x_q != '0) || (pend_y_q != '0) || (buttons != btn_last_q));
  assign hs    = tvalid_q & out_tready;

  // Velocity integration, per-report step and edge clamping.
  always_comb begin
    frac_x_d = frac_x_q;
    frac_y_d = frac_y_q;
    sat_d    = sat_q;

    // Fraction is non-negative, so the floor shift carries sub-pixel motion.
    sum_x = $signed(AW'(frac_x_q)) + AW'($signed(vx_in));
    sum_y = $signed(AW'(frac_y_q)) + AW'($signed(vy_in));
    int_x = sum_x >>> FRAC_BITS;
    int_y = sum_y >>> FRAC_BITS;

    step_x = clamp_s(AW'(pend_x_q), STEP_LO, STEP_HI);
    step_y = clamp_s(AW'(pend_y_q), STEP_LO, STEP_HI);

    // Off-screen excess is dropped: only the clamped move is reported.
    tgt_x = clamp_s($signed(AW'(pos_x_q)) + step_x, ZERO, X_MAX);
    tgt_y = clamp_s($signed(AW'(pos_y_q)) + step_y, ZERO, Y_MAX);
    eff_x = BYTE_W'(tgt_x - $signed(AW'(pos_x_q)));
    eff_y = BYTE_W'(tgt_y - $signed(AW'(pos_y_q)));

    // Latch consumes the pre-update pend; a same-cycle sample adds on top.
    raw_x = AW'(pend_x_q) - (latch ? step_x : ZERO) + (valid ? int_x : ZERO);
    raw_y = AW'(pend_y_q) - (latch ? step_y : ZERO) + (valid ? int_y : ZERO);

    pend_x_d = PW'(clamp_s(raw_x, PEND_LO, PEND_HI));
    pend_y_d = PW'(clamp_s(raw_y, PEND_LO, PEND_HI));

    if ((raw_x > PEND_HI) || (raw_x < PEND_LO) ||
        (raw_y > PEND_HI) || (raw_y < PEND_LO)) begin
      sat_d = 1'b1;
    end

    if (valid) begin
      frac_x_d = sum_x[FRAC_BITS-1:0];
      frac_y_d = sum_y[FRAC_BITS-1:0];
    end
  end

  // Report sequencer: next state, registered stream outputs, position.
  always_comb begin
    state_d    = state_q;
    tdata_d    = tdata_q;
    tvalid_d   = tvalid_q;
    tlast_d    = tlast_q;
    pos_x_d    = pos_x_q;
    pos_y_d    = pos_y_q;
    ex_d       = ex_q;
    ey_d       = ey_q;
    btn_last_d = btn_last_q;

    case (state_q)
      ST_IDLE: begin
        if (latch) begin
          state_d    = ST_BTN;
          tvalid_d   = 1'b1;
          tlast_d    = 1'b0;
          tdata_d    = {5'b0, buttons};
          btn_last_d = buttons;
          pos_x_d    = POS_W'(tgt_x);
          pos_y_d    = POS_W'(tgt_y);
          ex_d       = eff_x;
          ey_d       = eff_y;
        end
      end
      ST_BTN: begin
        if (hs) begin
          state_d = ST_DX;
          tdata_d = ex_q;
        end
      end
      ST_DX: begin
        if (hs) begin
          state_d = ST_DY;
          tdata_d = ey_q;
          tlast_d = 1'b1;
        end
      end
      ST_DY: begin
        if (hs) begin
          state_d  = ST_IDLE;
          tvalid_d = 1'b0;
          tlast_d  = 1'b0;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        tvalid_d = 1'b0;
        tlast_d  = 1'b0;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      frac_x_q   <= '0;
      frac_y_q   <= '0;
      pend_x_q   <= '0;
      pend_y_q   <= '0;
      pos_x_q    <= POS_W'(SCREEN_W / 2);
      pos_y_q    <= POS_W'(SCREEN_H / 2);
      btn_last_q <= '0;
      ex_q       <= '0;
      ey_q       <= '0;
      tdata_q    <= '0;
      tvalid_q   <= 1'b0;
      tlast_q    <= 1'b0;
      sat_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      frac_x_q   <= frac_x_d;
      frac_y_q   <= frac_y_d;
      pend_x_q   <= pend_x_d;
      pend_y_q   <= pend_y_d;
      pos_x_q    <= pos_x_d;
      pos_y_q    <= pos_y_d;
      btn_last_q <= btn_last_d;
      ex_q       <= ex_d;
      ey_q       <= ey_d;
      tdata_q    <= tdata_d;
      tvalid_q   <= tvalid_d;
      tlast_q    <= tlast_d;
      sat_q      <= sat_d;
    end
  end

  assign out_tdata  = tdata_q;
  assign out_tvalid = tvalid_q;
  assign out_tlast  = tlast_q;
  assign pos_x      = pos_x_q;
  assign pos_y      = pos_y_q;
  assign sat_flag   = sat_q;

endmodule

// File: tb/tb_boreal_cursor_reporter.sv
// Testbench for boreal_cursor_reporter: directed and random stimulus checked
// against a transaction-level model (integer arithmetic plus expected-byte queue).
module tb_boreal_cursor_reporter;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic [23:0] vx_in, vy_in;
  logic        enable;
  logic [2:0]  buttons;
  logic [7:0]  out_tdata;
  logic        out_tvalid;
  logic        out_tready;
  logic        out_tlast;
  logic [11:0] pos_x, pos_y;
  logic        sat_flag;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int         m_pos_x, m_pos_y, m_frac_x, m_frac_y, m_pend_x, m_pend_y, m_out;
  logic [2:0] m_btn_last;
  bit         m_sat;
  logic [8:0] exp_q[$];
  logic [8:0] got_q[$];

  boreal_cursor_reporter dut (
    .clk(clk), .rst(rst), .valid(valid), .vx_in(vx_in), .vy_in(vy_in),
    .enable(enable), .buttons(buttons), .out_tdata(out_tdata),
    .out_tvalid(out_tvalid), .out_tready(out_tready), .out_tlast(out_tlast),
    .pos_x(pos_x), .pos_y(pos_y), .sat_flag(sat_flag)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic int clampi(int v, int lo, int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  task automatic model_reset();
    m_pos_x = 960; m_pos_y = 540;
    m_frac_x = 0; m_frac_y = 0; m_pend_x = 0; m_pend_y = 0;
    m_out = 0; m_btn_last = 3'b000; m_sat = 0;
  endtask

  // One clock: record DUT handshakes, advance the model, return 1 ns past the edge.
  task automatic tick();
    int sx, sy, tx, ty, ex, ey, sum;
    bit lat;
    @(negedge clk);
    if (rst) begin
      model_reset();
    end else begin
      if (out_tvalid && out_tready) got_q.push_back({out_tlast, out_tdata});
      lat = (m_out == 0) && enable &&
            (m_pend_x != 0 || m_pend_y != 0 || buttons != m_btn_last);
      if (!lat && m_out > 0 && out_tready) m_out--;
      if (lat) begin
        sx = clampi(m_pend_x, -127, 127);
        sy = clampi(m_pend_y, -127, 127);
        tx = clampi(m_pos_x + sx, 0, 1919);
        ty = clampi(m_pos_y + sy, 0, 1079);
        ex = tx - m_pos_x;
        ey = ty - m_pos_y;
        m_pos_x = tx; m_pos_y = ty;
        m_pend_x -= sx; m_pend_y -= sy;
        exp_q.push_back({1'b0, 5'b0, buttons});
        exp_q.push_back({1'b0, 8'(ex)});
        exp_q.push_back({1'b1, 8'(ey)});
        m_btn_last = buttons;
        m_out = 3;
      end
      if (valid) begin
        sum = m_frac_x + int'($signed(vx_in));
        m_pend_x += (sum >>> 8);
        m_frac_x = sum & 255;
        sum = m_frac_y + int'($signed(vy_in));
        m_pend_y += (sum >>> 8);
        m_frac_y = sum & 255;
      end
      if (m_pend_x > 32767)  begin m_pend_x = 32767;  m_sat = 1; end
      if (m_pend_x < -32767) begin m_pend_x = -32767; m_sat = 1; end
      if (m_pend_y > 32767)  begin m_pend_y = 32767;  m_sat = 1; end
      if (m_pend_y < -32767) begin m_pend_y = -32767; m_sat = 1; end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; valid = 1'b0; enable = 1'b0; out_tready = 1'b0;
    buttons = 3'b000; vx_in = '0; vy_in = '0;
    tick();
    tick();
    rst = 1'b0;
    exp_q.delete();
    got_q.delete();
  endtask

  // Let the model (and DUT) finish every pending report.
  task automatic drain();
    valid = 1'b0; enable = 1'b1; out_tready = 1'b1;
    for (int i = 0; i < 5000; i++) begin
      if (m_out == 0 && m_pend_x == 0 && m_pend_y == 0 && buttons == m_btn_last) break;
      tick();
    end
    tick();
  endtask

  task automatic send(input logic [23:0] vx, input logic [23:0] vy);
    vx_in = vx; vy_in = vy; valid = 1'b1;
    tick();
    valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (out_tvalid !== 1'b0) begin failures++; $display("FAIL reset_tvalid: got %b want 0", out_tvalid); end
    checks++; if (out_tdata !== 8'h00) begin failures++; $display("FAIL reset_tdata: got %h want 00", out_tdata); end
    checks++; if (out_tlast !== 1'b0) begin failures++; $display("FAIL reset_tlast: got %b want 0", out_tlast); end
    checks++; if (pos_x !== 12'd960) begin failures++; $display("FAIL reset_pos_x: got %0d want 960", pos_x); end
    checks++; if (pos_y !== 12'd540) begin failures++; $display("FAIL reset_pos_y: got %0d want 540", pos_y); end
    checks++; if (sat_flag !== 1'b0) begin failures++; $display("FAIL reset_sat: got %b want 0", sat_flag); end
  endtask

  task automatic test_frac_carry();
    do_reset();
    enable = 1'b1; out_tready = 1'b1;
    vx_in = 24'h000180; vy_in = '0; valid = 1'b1;
    tick();
    tick();
    valid = 1'b0;
    drain();
    checks++;
    if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL frac_len: got %0d bytes want %0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL frac_byte%0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (pos_x !== 12'd963) begin failures++; $display("FAIL frac_pos_x: got %0d want 963", pos_x); end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_big_move();
    do_reset();
    send(24'h012C00, 24'h000000);
    drain();
    checks++;
    if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL big_len: got %0d bytes want %0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL big_byte%0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (pos_x !== 12'd1260) begin failures++; $display("FAIL big_pos_x: got %0d want 1260", pos_x); end
    checks++; if (pos_y !== 12'd540) begin failures++; $display("FAIL big_pos_y: got %0d want 540", pos_y); end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_floor();
    do_reset();
    send(24'hFFFF80, 24'h000000);
    drain();
    send(24'hFFFF80, 24'h000000);
    drain();
    checks++;
    if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL floor_len: got %0d bytes want %0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL floor_byte%0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (pos_x !== 12'(m_pos_x)) begin failures++; $display("FAIL floor_pos_x: got %0d want %0d", pos_x, m_pos_x); end
    checks++; if (got_q.size() < 2 || got_q[1] !== 9'h0FF) begin failures++; $display("FAIL floor_dx: got %h want 0ff", (got_q.size() > 1) ? got_q[1] : 9'h1FF); end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_edge_clamp();
    do_reset();
    send(24'h03AC00, 24'h000000);
    drain();
    checks++; if (pos_x !== 12'd1900) begin failures++; $display("FAIL clamp_pos_1900: got %0d want 1900", pos_x); end
    exp_q.delete(); got_q.delete();
    send(24'h006400, 24'h000000);
    drain();
    checks++; if (pos_x !== 12'd1919) begin failures++; $display("FAIL clamp_pos_1919: got %0d want 1919", pos_x); end
    checks++; if (got_q.size() != 3 || got_q[1] !== 9'h013) begin failures++; $display("FAIL clamp_dx19: got %0d bytes, dx %h want 013", got_q.size(), (got_q.size() > 1) ? got_q[1] : 9'h1FF); end
    send(24'h003200, 24'h000000);
    drain();
    checks++;
    if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL clamp_len: got %0d bytes want %0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL clamp_byte%0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (pos_x !== 12'd1919) begin failures++; $display("FAIL clamp_pos_pinned: got %0d want 1919", pos_x); end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_backpressure();
    do_reset();
    buttons = 3'b001; enable = 1'b1; out_tready = 1'b0;
    tick();
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++;
      if (out_tvalid !== 1'b1 || out_tdata !== 8'h01 || out_tlast !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold%0d: got valid=%b data=%h last=%b want 1/01/0", c, out_tvalid, out_tdata, out_tlast);
      end
    end
    drain();
    checks++;
    if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL bp_len: got %0d bytes want %0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL bp_byte%0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_reset_mid_and_sat();
    do_reset();
    enable = 1'b1; out_tready = 1'b1;
    send(24'h000A00, 24'h000000);
    tick();
    tick();
    checks++; if (out_tvalid !== 1'b1 || out_tdata !== 8'h0A) begin failures++; $display("FAIL mid_dx_byte: got valid=%b data=%h want 1/0a", out_tvalid, out_tdata); end
    rst = 1'b1;
    tick();
    checks++; if (out_tvalid !== 1'b0) begin failures++; $display("FAIL mid_abort_tvalid: got %b want 0", out_tvalid); end
    checks++; if (pos_x !== 12'd960 || pos_y !== 12'd540) begin failures++; $display("FAIL mid_abort_pos: got %0d/%0d want 960/540", pos_x, pos_y); end
    checks++; if (sat_flag !== 1'b0) begin failures++; $display("FAIL mid_abort_sat: got %b want 0", sat_flag); end
    rst = 1'b0; enable = 1'b0;
    exp_q.delete(); got_q.delete();
    vx_in = 24'h7FFFFF; vy_in = '0; valid = 1'b1;
    for (int i = 0; i < 200; i++) tick();
    valid = 1'b0;
    checks++; if (sat_flag !== 1'b1 || !m_sat) begin failures++; $display("FAIL sat_set: got %b want 1", sat_flag); end
    drain();
    checks++;
    if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL sat_len: got %0d bytes want %0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL sat_byte%0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (pos_x !== 12'd1919) begin failures++; $display("FAIL sat_pos_x: got %0d want 1919", pos_x); end
    checks++; if (sat_flag !== 1'b1) begin failures++; $display("FAIL sat_sticky: got %b want 1", sat_flag); end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_back_to_back();
    do_reset();
    enable = 1'b1; out_tready = 1'b1;
    send(24'h012C00, 24'h000000);
    checks++; if (out_tvalid !== 1'b0) begin failures++; $display("FAIL b2b_latency0: got %b want 0", out_tvalid); end
    for (int k = 0; k < 12; k++) begin
      tick();
      checks++;
      if (out_tvalid !== ((k % 4) != 3)) begin
        failures++;
        $display("FAIL b2b_tvalid_cyc%0d: got %b want %b", k, out_tvalid, ((k % 4) != 3));
      end
    end
    drain();
    checks++;
    if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL b2b_len: got %0d bytes want %0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL b2b_byte%0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_random();
    int r;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      valid      = ($urandom_range(0, 2) != 0);
      enable     = ($urandom_range(0, 9) != 0);
      out_tready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) buttons = 3'($urandom_range(0, 7));
      r = int'($urandom_range(0, 20480)) - 10240;
      if ($urandom_range(0, 99) == 0) r = ($urandom_range(0, 1) != 0) ? 8388607 : -8388607;
      vx_in = 24'(r);
      r = int'($urandom_range(0, 20480)) - 10240;
      vy_in = 24'(r);
      tick();
    end
    drain();
    checks++;
    if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL rand_len: got %0d bytes want %0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL rand_byte%0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (pos_x !== 12'(m_pos_x) || pos_y !== 12'(m_pos_y)) begin failures++; $display("FAIL rand_pos: got %0d/%0d want %0d/%0d", pos_x, pos_y, m_pos_x, m_pos_y); end
    checks++; if (sat_flag !== m_sat) begin failures++; $display("FAIL rand_sat: got %b want %b", sat_flag, m_sat); end
    exp_q.delete(); got_q.delete();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_frac_carry();
    test_big_move();
    test_floor();
    test_edge_clamp();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_and_sat();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
